// File: rtl/speed_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : speed_sched_pkg
// Brief    : Shared types and constants for the round-robin rate scheduler.
// Revision : 1.0
// ============================================================================
package speed_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GUARD   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } sched_st_t;

  localparam int MBPS_SHIFT = 20;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/speed_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : First set mask bit at or above ptr, searching with wrap.
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int NCH  = 4,
  parameter int CH_W = 2
) (
  input  logic [NCH-1:0]  ch_mask,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] pick,
  output logic            any
);

  logic [CH_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the closest hit wins.
  always_comb begin
    pick  = '0;
    w_idx = '0;
    any   = |ch_mask;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = CH_W'((int'(ptr) + i) % NCH);
      if (ch_mask[w_idx]) pick = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/speed_sched.sv
`default_nettype none
// ============================================================================
// Module   : speed_sched
// Brief    : Round-robin byte-rate measurement over NCH channels sharing one
//            saturating accumulator; results leave on a valid/ready port.
// Revision : 1.0
// ============================================================================
module speed_sched
  import speed_sched_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int NBytes    = 4,
  parameter int STS_W     = 48,
  parameter int WIN_CYC   = 100000000,
  parameter int GUARD_CYC = 4,
  localparam int CH_W     = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [NCH-1:0]   ch_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic [STS_W-1:0] res_bps,
  output logic [STS_W-1:0] res_mbps,
  output logic             res_ovf,
  output logic             busy
);

  sched_st_t        r_state;
  sched_st_t        w_state_nxt;
  logic [CH_W-1:0]  r_ptr;
  logic [CH_W-1:0]  r_cur_ch;
  logic [STS_W-1:0] r_acc;
  logic             r_ovf;
  logic [31:0]      r_guard_cnt;
  logic [31:0]      r_win_cnt;
  logic [CH_W-1:0]  r_res_ch;
  logic [STS_W-1:0] r_res_bps;
  logic [STS_W-1:0] r_res_mbps;
  logic             r_res_ovf;

  logic [CH_W-1:0]  w_ptr_nxt;
  logic [CH_W-1:0]  w_pick_ptr;
  logic [CH_W-1:0]  w_pick;
  logic             w_any;
  logic             w_accept;
  logic             w_start;
  logic             w_guard_done;
  logic             w_win_done;
  logic [STS_W:0]   w_sum;
  logic [STS_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  localparam sched_st_t c_first_st = (GUARD_CYC == 0) ? ST_MEASURE : ST_GUARD;

  assign w_accept     = (r_state == ST_REPORT) && res_ready;
  assign w_ptr_nxt    = (r_res_ch == CH_W'(NCH - 1)) ? '0 : r_res_ch + CH_W'(1);
  // On acceptance the pick must already see the advanced pointer.
  assign w_pick_ptr   = w_accept ? w_ptr_nxt : r_ptr;
  assign w_start      = enable && w_any && ((r_state == ST_IDLE) || w_accept);
  assign w_guard_done = (r_guard_cnt == 32'(GUARD_CYC - 1));
  assign w_win_done   = (r_state == ST_MEASURE) && enable &&
                        (r_win_cnt == 32'(WIN_CYC - 1));

  rr_pick #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr_pick (
    .ch_mask (ch_mask),
    .ptr     (w_pick_ptr),
    .pick    (w_pick),
    .any     (w_any)
  );

  always_comb begin
    w_sum     = {1'b0, r_acc} + (STS_W + 1)'(NBytes);
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (ch_en[r_cur_ch]) begin
      if (w_sum[STS_W]) begin
        w_acc_nxt = '1;
        w_ovf_nxt = 1'b1;
      end else begin
        w_acc_nxt = w_sum[STS_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = c_first_st;
      ST_GUARD:   if (!enable) w_state_nxt = ST_IDLE;
                  else if (w_guard_done) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (!enable) w_state_nxt = ST_IDLE;
                  else if (w_win_done) w_state_nxt = ST_REPORT;
      ST_REPORT:  if (w_accept) w_state_nxt = w_start ? c_first_st : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cur_ch    <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_guard_cnt <= '0;
      r_win_cnt   <= '0;
      r_res_ch    <= '0;
      r_res_bps   <= '0;
      r_res_mbps  <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cur_ch    <= w_pick;
        r_acc       <= '0;
        r_ovf       <= 1'b0;
        r_guard_cnt <= '0;
        r_win_cnt   <= '0;
      end else if (r_state == ST_GUARD) begin
        r_guard_cnt <= r_guard_cnt + 32'd1;
      end else if (r_state == ST_MEASURE) begin
        r_win_cnt <= r_win_cnt + 32'd1;
        r_acc     <= w_acc_nxt;
        r_ovf     <= w_ovf_nxt;
      end
      if (w_win_done) begin
        r_res_ch   <= r_cur_ch;
        r_res_bps  <= w_acc_nxt;
        r_res_mbps <= w_acc_nxt >> MBPS_SHIFT;
        r_res_ovf  <= w_ovf_nxt;
      end
      if (w_accept) r_ptr <= w_ptr_nxt;
    end
  end

  assign res_valid = (r_state == ST_REPORT);
  assign busy      = (r_state != ST_IDLE);
  assign res_ch    = r_res_ch;
  assign res_bps   = r_res_bps;
  assign res_mbps  = r_res_mbps;
  assign res_ovf   = r_res_ovf;

endmodule
`default_nettype wire

// File: tb/tb_speed_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_sched
// Brief    : Directed self-checking bench for speed_sched.
// Revision : 1.0
// ============================================================================
module tb_speed_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable, res_ready, tog_mode, r_tog;
  logic [3:0]  ch_mask, ch_en_base, ch_en;
  logic        res_valid, res_ovf, busy;
  logic [1:0]  res_ch;
  logic [47:0] res_bps, res_mbps;

  logic        b_enable, b_ready, b_valid, b_ovf, b_busy;
  logic [3:0]  b_mask, b_ch_en;
  logic [1:0]  b_ch;
  logic [5:0]  b_bps, b_mbps;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) r_tog <= tog_mode ? ~r_tog : 1'b0;
  assign ch_en = {ch_en_base[3:2], tog_mode ? r_tog : ch_en_base[1], ch_en_base[0]};

  speed_sched #(.NCH(4), .NBytes(4), .STS_W(48), .WIN_CYC(16), .GUARD_CYC(2)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .ch_mask(ch_mask),
    .ch_en(ch_en), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_bps(res_bps), .res_mbps(res_mbps), .res_ovf(res_ovf), .busy(busy));

  speed_sched #(.NCH(4), .NBytes(4), .STS_W(6), .WIN_CYC(20), .GUARD_CYC(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(b_enable), .ch_mask(b_mask),
    .ch_en(b_ch_en), .res_valid(b_valid), .res_ready(b_ready), .res_ch(b_ch),
    .res_bps(b_bps), .res_mbps(b_mbps), .res_ovf(b_ovf), .busy(b_busy));

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_a(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!res_valid && cyc < 200);
    check("a_result_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!b_valid && cyc < 200);
    check("b_result_timeout", 64'(b_valid), 64'd1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0; enable = 0; res_ready = 0; tog_mode = 0;
    ch_mask = 0; ch_en_base = 0;
    b_enable = 0; b_ready = 0; b_mask = 0; b_ch_en = 0;
    tick(); tick();
    sys_rst_n = 1'b1;

    check("rst_valid", 64'(res_valid), 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_bps",   64'(res_bps), 0);
    check("rst_ch",    64'(res_ch), 0);
    check("rst_ovf",   64'(res_ovf), 0);

    // Saturation on the narrow instance
    b_mask = 4'hF; b_ch_en = 4'b0001; b_ready = 1; b_enable = 1;
    wait_b(n);
    check("sat_latency", 64'(n), 23);
    check("sat_ch",   64'(b_ch), 0);
    check("sat_bps",  64'(b_bps), 63);
    check("sat_ovf",  64'(b_ovf), 1);
    check("sat_mbps", 64'(b_mbps), 0);
    wait_b(n);
    check("sat2_ch",  64'(b_ch), 1);
    check("sat2_bps", 64'(b_bps), 0);
    check("sat2_ovf", 64'(b_ovf), 0);
    b_enable = 0;

    // Basic rotation and latency
    do_reset();
    ch_mask = 4'hF; ch_en_base = 4'b0001; res_ready = 1; enable = 1;
    wait_a(n);
    check("t1_latency", 64'(n), 19);
    check("t1_ch",   64'(res_ch), 0);
    check("t1_bps",  64'(res_bps), 64);
    check("t1_mbps", 64'(res_mbps), 0);
    check("t1_ovf",  64'(res_ovf), 0);
    tick();
    check("t1_valid_drop", 64'(res_valid), 0);
    wait_a(n);
    check("t1_period", 64'(n), 18);
    check("t1b_ch",  64'(res_ch), 1);
    check("t1b_bps", 64'(res_bps), 0);

    // Sparse mask with toggling strobe on channel 1
    enable = 0;
    do_reset();
    ch_mask = 4'b1010; ch_en_base = 4'b0000; tog_mode = 1; enable = 1;
    for (int k = 0; k < 4; k++) begin
      wait_a(n);
      check("t2_ch", 64'(res_ch), (k % 2 == 0) ? 64'd1 : 64'd3);
      check("t2_bps", 64'(res_bps), (k % 2 == 0) ? 64'd32 : 64'd0);
    end
    tog_mode = 0;

    // Back-pressure stall in REPORT
    enable = 0;
    do_reset();
    ch_mask = 4'hF; ch_en_base = 4'b0001; res_ready = 0; enable = 1;
    wait_a(n);
    check("t3_latency", 64'(n), 19);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_stall_valid", 64'(res_valid), 1);
      check("t3_stall_bps",   64'(res_bps), 64);
      check("t3_stall_ch",    64'(res_ch), 0);
    end
    res_ready = 1;
    tick();
    check("t3_accept_valid", 64'(res_valid), 0);
    check("t3_accept_busy",  64'(busy), 1);
    wait_a(n);
    check("t3_next_latency", 64'(n), 18);
    check("t3_next_ch", 64'(res_ch), 1);

    // Abort in the middle of channel 2's window
    tick(); tick(); tick();
    repeat (7) tick();
    enable = 0;
    tick();
    check("t4_abort_busy",  64'(busy), 0);
    check("t4_abort_valid", 64'(res_valid), 0);
    repeat (3) tick();
    check("t4_idle_valid", 64'(res_valid), 0);
    ch_en_base = 4'b0100;
    enable = 1;
    wait_a(n);
    check("t4_latency", 64'(n), 19);
    check("t4_ch",  64'(res_ch), 2);
    check("t4_bps", 64'(res_bps), 64);

    // Asynchronous reset while a result is pending
    res_ready = 0;
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(res_valid), 0);
    check("t6_rst_busy",  64'(busy), 0);
    check("t6_rst_bps",   64'(res_bps), 0);
    #2;
    sys_rst_n = 1'b1;
    res_ready = 1;
    wait_a(n);
    check("t6_latency", 64'(n), 19);
    check("t6_ch",  64'(res_ch), 0);
    check("t6_bps", 64'(res_bps), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/speed_sched.md
# speed_sched

Round-robin measurement scheduler that shares one byte-rate accumulator between NCH traffic channels of the TCPv4 client debug path. Each channel's data-enable strobe is sampled in turn for a fixed window. Between windows the accumulator is cleared for a guard interval. Each window's result is presented on a valid/ready port, tagged with its channel number, for the debug register bank or ILA capture.

## Interface
Parameters:
- NCH, 4: number of channels (2..16).
- NBytes, 4: bytes credited per sampled enable cycle.
- STS_W, 48: accumulator/result width.
- WIN_CYC, 100000000: measurement window length in cycles (≥1).
- GUARD_CYC, 4: cycles between windows (≥0).

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- enable, in, 1: run scheduler.
- ch_mask, in, NCH: 1 = channel takes part in the rotation.
- ch_en, in, NCH: per-channel data-enable strobes.
- res_valid, out, 1: result available.
- res_ready, in, 1: consumer accepts result.
- res_ch, out, CH_W = max(1, clog2(NCH)): channel the result belongs to.
- res_bps, out, STS_W: bytes counted in the window.
- res_mbps, out, STS_W: res_bps >> 20, zero-extended.
- res_ovf, out, 1: accumulator saturated during the window.
- busy, out, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, GUARD, MEASURE, REPORT.
- Pointer ptr starts at reset value 0. pick = first channel with ch_mask set, searching from ptr upward with wrap.
- IDLE: if enable=1 and ch_mask≠0, latch cur_ch=pick and clear acc/ovf. Next state is GUARD, or MEASURE when GUARD_CYC=0. Otherwise stay in IDLE.
- GUARD: hold for GUARD_CYC cycles with acc held at 0, then go to MEASURE.
- MEASURE: runs exactly WIN_CYC cycles. Each cycle with ch_en[cur_ch]=1 adds NBytes to acc.
  - If the add would exceed 2^STS_W−1, acc = all-ones and ovf=1.
  - The sample taken on the last cycle is included in the result.
  - Then load res_* from the final acc and go to REPORT.
- REPORT: res_valid=1. The result is accepted on the cycle where res_valid and res_ready are both 1. On acceptance:
  - ptr = (res_ch+1) mod NCH.
  - If enable=1 and ch_mask≠0, take the same branch as IDLE, so there is no idle cycle.
  - Otherwise go to IDLE.
- enable=0 in GUARD or MEASURE aborts to IDLE on the next edge. No result is produced and ptr is unchanged, so the same channel is re-measured when enable returns.
- enable=0 in REPORT does not cancel the pending result; it is still presented until accepted.
- ch_mask is sampled only when a channel is picked. Changes during GUARD, MEASURE or REPORT have no effect.
- ch_en for channels other than cur_ch is ignored.
- ch_en is ignored in IDLE, GUARD and REPORT.

## Timing
- Reset values: all outputs 0, state IDLE, ptr 0, acc 0. Reset takes effect immediately, including in mid-window or mid-REPORT.
- Latency from the enable edge to res_valid = 1 + GUARD_CYC + WIN_CYC cycles.
- res_ch, res_bps, res_mbps and res_ovf are registered and stable whenever res_valid=1.
- res_valid deasserts the cycle after acceptance.
- res_* keep their last values while res_valid=0.
- With res_ready held at 1, back-to-back result period = 1 + GUARD_CYC + WIN_CYC cycles.

## Structure
- Package speed_sched_pkg holds:
  - the state enum (sched_st_t);
  - a clog2 function;
  - the MBPS_SHIFT=20 constant.
- Sub-module rr_pick computes pick and any = |ch_mask from ch_mask and ptr. It is purely combinational, parameterised by NCH.
- Window and guard counters sit in speed_sched; each is 32 bits wide.

## Test plan
Bench settings: NCH=4, NBytes=4, STS_W=48, WIN_CYC=16, GUARD_CYC=2, res_ready=1 unless stated.
1. ch_mask=4'hF, ch_en[0]=1 constant, others 0, enable raised → first result res_ch=0, res_bps=64, res_mbps=0 at 19 cycles after enable. Next result res_ch=1, res_bps=0.
2. ch_mask=4'b1010, ch_en[1] toggling every other cycle → results arrive in channel order 1,3,1,3, with channel-1 results res_bps=32.
3. res_ready held low for 10 cycles in REPORT → res_valid and res_* stable for the whole stall, and no new window starts. Accepted on the 11th cycle → GUARD begins next cycle.
4. enable dropped in cycle 8 of ch2's MEASURE → IDLE, no res_valid. Re-enable → ch2 is measured again.
5. STS_W=6, WIN_CYC=20, ch_en[0]=1 constant → res_bps=63, res_ovf=1. Next window res_ovf=0.
6. sys_rst_n pulsed low mid-REPORT, asynchronous to clock → res_valid=0 and busy=0 before the next edge. After release the first result is for res_ch=0.
